stage_controller: RTL and testbench
===================================

STAGE_CONTROLLER -- requirements
Module: stage_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC and next-PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000, meaning PC loaded on reset.
REQ-003 SHALL have parameter CNT_W, default 32, meaning retire counter width.
REQ-004 SHALL have parameter SKIP_MA, default 1, meaning 1 = bypass MA stage for non-memory instructions.
REQ-005 SHALL have parameter WAIT_MAX, default 255, meaning the maximum number of cycles to wait for an ack; 0 = wait forever.
REQ-006 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-009 SHALL have port imem_ack, input, 1, instruction word valid.
REQ-010 SHALL have port dmem_req, output, 1, data memory access request.
REQ-011 SHALL have port dmem_we, output, 1, data memory write strobe.
REQ-012 SHALL have port dmem_ack, input, 1, data access complete.
REQ-013 SHALL have ports is_load, is_store, is_halt and reg_we_dec, each input, 1, decoded instruction class, valid from EX onward.
REQ-014 SHALL have port npc, input, XLEN, next PC from the next-PC generator.
REQ-015 SHALL have port pc, output, XLEN, current instruction address.
REQ-016 SHALL have port stage, output, 3, current state encoding.
REQ-017 SHALL have ports dec_clear and alu_clear, each output, 1, one-cycle clears to the decoder and the ALU.
REQ-018 SHALL have port reg_we, output, 1, register-file write enable.
REQ-019 SHALL have ports halted and timeout_err, each output, 1, halt status and handshake-timeout status.
REQ-020 SHALL have port retire_cnt, output, CNT_W, count of retired instructions.

Function
REQ-021 SHALL implement states IF=0, RR=1, EX=2, MA=3, RW=4, HALT=5; stage SHALL equal the state register.
REQ-022 SHALL drive imem_req = 1 iff state is IF; IF->RR on the first cycle imem_ack=1, including the first IF cycle.
REQ-023 SHALL assert dec_clear only in RR and alu_clear only in EX; RR->EX and EX->next SHALL be unconditional single cycles.
REQ-024 In EX, SHALL go to HALT if is_halt=1, regardless of is_load/is_store.
REQ-025 In EX without halt, SHALL go to MA if is_load|is_store, else to RW when SKIP_MA=1 or to MA when SKIP_MA=0.
REQ-026 In MA, SHALL drive dmem_req = is_load|is_store and dmem_we = is_store.
REQ-027 MA->RW SHALL occur on dmem_ack=1 for memory instructions, or after exactly one cycle for non-memory instructions.
REQ-028 SHALL ignore imem_ack outside IF and dmem_ack outside MA or when dmem_req=0.
REQ-029 SHALL assert reg_we = reg_we_dec for exactly the single RW cycle.
REQ-030 On RW->IF, SHALL load pc <= npc and increment retire_cnt by 1, wrapping modulo 2^CNT_W.
REQ-031 SHALL keep pc constant in all other states; HALT SHALL keep pc at the halting instruction's address.
REQ-032 SHALL count wait cycles in IF and MA (when dmem_req=1) and clear the count on entering either state.
REQ-033 If WAIT_MAX != 0 and the wait count reaches WAIT_MAX without an ack, SHALL set timeout_err=1 and enter HALT next cycle.
REQ-034 An ack in the same cycle the count reaches WAIT_MAX SHALL take priority, with no timeout.
REQ-035 HALT SHALL be absorbing until rst; in HALT, halted=1 and imem_req, dmem_req, dmem_we and reg_we SHALL be 0.
REQ-036 A halting instruction SHALL NOT retire: no retire_cnt increment and no pc update.

Reset
REQ-037 On rst=1 at a clock edge, SHALL set state=IF, pc=RESET_PC, retire_cnt=0, halted=0, timeout_err=0 and wait count=0.
REQ-038 While rst is asserted, outputs SHALL be pc=RESET_PC, retire_cnt=0, halted=0, timeout_err=0, dmem_req=0, dmem_we=0, reg_we=0, dec_clear=0, alu_clear=0.
REQ-039 imem_req SHALL be 1 from the first cycle after rst deasserts.
REQ-040 Reset asserted mid-MA SHALL drop dmem_req on the next cycle with no reg_we pulse and no retire.

Verification
REQ-041 Add instruction, acks immediate, SKIP_MA=1, npc=8004 -> stages IF,RR,EX,RW; reg_we pulse in RW; pc=8004 and retire_cnt=1 after 4 cycles.
REQ-042 Store with dmem_ack delayed 3 cycles -> dmem_req=dmem_we=1 for 4 MA cycles, reg_we=0, retire_cnt=1; SKIP_MA=0 non-memory op spends exactly 1 MA cycle.
REQ-043 is_halt=1 with is_store=1 at pc=8010 -> HALT after EX; dmem_req never 1; pc stays 8010; retire_cnt unchanged; state held 100 cycles.
REQ-044 WAIT_MAX=4 and imem_ack held 0 -> timeout_err=1 and HALT; ack arriving on the 4th wait cycle -> RR with no error.
REQ-045 CNT_W=4, 16 retired instructions -> retire_cnt wraps to 0; rst in MA -> IF with pc=8000, retire_cnt=0, dmem_req=0 next cycle.

Source files
------------

// File: rtl/stage_controller.sv
// Sequencing controller for a multi-cycle core: walks each instruction through
// IF/RR/EX/MA/RW, owns the PC and retire counter, and halts on halt or handshake timeout.
module stage_controller #(
    parameter int          XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000,
    parameter int          CNT_W    = 32,
    parameter bit          SKIP_MA  = 1'b1,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             reg_we_dec,
    input  logic [XLEN-1:0]  npc,
    output logic [XLEN-1:0]  pc,
    output logic [2:0]       stage,
    output logic             dec_clear,
    output logic             alu_clear,
    output logic             reg_we,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retire_cnt
);

    // wait_q counts cycles already spent waiting in the current IF/MA visit;
    // the timeout fires on the cycle whose ordinal equals WAIT_MAX.
    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_MAX == 0) ? '0 : WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_RR   = 3'd1,
        ST_EX   = 3'd2,
        ST_MA   = 3'd3,
        ST_RW   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WAIT_W-1:0] wait_q;
    logic              tmo_q;

    logic mem_op;
    logic wait_hit;
    logic wait_inc;
    logic tmo_set;
    logic retire;

    assign mem_op   = is_load | is_store;
    assign wait_hit = (WAIT_MAX != 0) && (wait_q == WAIT_LAST);

    // Handshakes: a request is held high for every cycle of its state; the
    // matching ack completes it on any cycle the request is high, and an ack
    // seen while the request is low is ignored. An ack beats a same-cycle timeout.
    always_comb begin
        state_d  = state_q;
        wait_inc = 1'b0;
        tmo_set  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            ST_IF: begin
                if (imem_ack) begin
                    state_d = ST_RR;
                end else if (wait_hit) begin
                    state_d = ST_HALT;
                    tmo_set = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_RR: state_d = ST_EX;
            ST_EX: begin
                if (is_halt)
                    state_d = ST_HALT;
                else if (mem_op || !SKIP_MA)
                    state_d = ST_MA;
                else
                    state_d = ST_RW;
            end
            ST_MA: begin
                if (!mem_op || dmem_ack) begin
                    state_d = ST_RW;
                end else if (wait_hit) begin
                    state_d = ST_HALT;
                    tmo_set = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_RW: begin
                state_d = ST_IF;
                retire  = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IF;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                pc_q  <= npc;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_d != state_q)
                wait_q <= '0;
            else if (wait_inc)
                wait_q <= wait_q + WAIT_W'(1);
            if (tmo_set)
                tmo_q <= 1'b1;
        end
    end

    // Outputs are forced to their reset values while rst is high, even before
    // the first clock edge has loaded the registers.
    assign stage       = state_q;
    assign imem_req    = !rst && (state_q == ST_IF);
    assign dec_clear   = !rst && (state_q == ST_RR);
    assign alu_clear   = !rst && (state_q == ST_EX);
    assign dmem_req    = !rst && (state_q == ST_MA) && mem_op;
    assign dmem_we     = !rst && (state_q == ST_MA) && is_store;
    assign reg_we      = !rst && (state_q == ST_RW) && reg_we_dec;
    assign halted      = !rst && (state_q == ST_HALT);
    assign timeout_err = !rst && tmo_q;
    assign pc          = rst ? RESET_PC : pc_q;
    assign retire_cnt  = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_stage_controller.sv
// Bench for stage_controller: directed vector table, hand sequences for halt,
// reset and wrap, and random instructions checked against an instruction-level trace model.
module tb_stage_controller;

    localparam logic [2:0] S_IF = 3'd0, S_RR = 3'd1, S_EX = 3'd2,
                           S_MA = 3'd3, S_RW = 3'd4, S_HALT = 3'd5;

    typedef struct {
        bit          ld, st, hlt, we;
        int          if_d, ma_d;
        logic [31:0] npc;
    } instr_t;

    typedef struct {
        bit          sel_b;
        instr_t      ins;
        logic [2:0]  exp_stage;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
        bit          exp_tmo;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic imem_ack, dmem_ack, is_load, is_store, is_halt, reg_we_dec;
    logic [31:0] npc;

    logic a_imem_req, a_dmem_req, a_dmem_we, a_dec_clear, a_alu_clear, a_reg_we, a_halted, a_tmo;
    logic [31:0] a_pc;
    logic [2:0]  a_stage;
    logic [3:0]  a_cnt;
    logic b_imem_req, b_dmem_req, b_dmem_we, b_dec_clear, b_alu_clear, b_reg_we, b_halted, b_tmo;
    logic [31:0] b_pc;
    logic [2:0]  b_stage;
    logic [31:0] b_cnt;

    stage_controller #(.XLEN(32), .RESET_PC(32'h8000), .CNT_W(4), .SKIP_MA(1'b1), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst_a), .imem_req(a_imem_req), .imem_ack(imem_ack),
        .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_ack(dmem_ack),
        .is_load(is_load), .is_store(is_store), .is_halt(is_halt), .reg_we_dec(reg_we_dec),
        .npc(npc), .pc(a_pc), .stage(a_stage), .dec_clear(a_dec_clear), .alu_clear(a_alu_clear),
        .reg_we(a_reg_we), .halted(a_halted), .timeout_err(a_tmo), .retire_cnt(a_cnt)
    );

    stage_controller #(.XLEN(32), .RESET_PC(32'h8000), .CNT_W(32), .SKIP_MA(1'b0), .WAIT_MAX(255)) dut_b (
        .clk(clk), .rst(rst_b), .imem_req(b_imem_req), .imem_ack(imem_ack),
        .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_ack(dmem_ack),
        .is_load(is_load), .is_store(is_store), .is_halt(is_halt), .reg_we_dec(reg_we_dec),
        .npc(npc), .pc(b_pc), .stage(b_stage), .dec_clear(b_dec_clear), .alu_clear(b_alu_clear),
        .reg_we(b_reg_we), .halted(b_halted), .timeout_err(b_tmo), .retire_cnt(b_cnt)
    );

    bit sel_b = 1'b0;
    logic o_imem_req, o_dmem_req, o_dmem_we, o_dec_clear, o_alu_clear, o_reg_we, o_halted, o_tmo;
    logic [31:0] o_pc, o_cnt;
    logic [2:0]  o_stage;
    assign o_imem_req  = sel_b ? b_imem_req  : a_imem_req;
    assign o_dmem_req  = sel_b ? b_dmem_req  : a_dmem_req;
    assign o_dmem_we   = sel_b ? b_dmem_we   : a_dmem_we;
    assign o_dec_clear = sel_b ? b_dec_clear : a_dec_clear;
    assign o_alu_clear = sel_b ? b_alu_clear : a_alu_clear;
    assign o_reg_we    = sel_b ? b_reg_we    : a_reg_we;
    assign o_halted    = sel_b ? b_halted    : a_halted;
    assign o_tmo       = sel_b ? b_tmo       : a_tmo;
    assign o_pc        = sel_b ? b_pc        : a_pc;
    assign o_cnt       = sel_b ? b_cnt       : {28'd0, a_cnt};
    assign o_stage     = sel_b ? b_stage     : a_stage;

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [2:0]  exp_q[$];
    logic [31:0] mdl_pc, mdl_cnt, cfg_mask;
    bit          mdl_halt, mdl_tmo, cfg_skip;
    int          cfg_wmax;
    logic [2:0]  prev_stage;
    int          runlen;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(bit ld, bit st, bit hlt, bit we, int if_d, int ma_d, logic [31:0] n);
        instr_t r;
        r.ld = ld; r.st = st; r.hlt = hlt; r.we = we; r.if_d = if_d; r.ma_d = ma_d; r.npc = n;
        return r;
    endfunction

    task automatic add_vec(bit sb, instr_t ins, logic [2:0] es, logic [31:0] ep, logic [31:0] ec, bit et);
        vec_t v;
        v.sel_b = sb; v.ins = ins; v.exp_stage = es; v.exp_pc = ep; v.exp_cnt = ec; v.exp_tmo = et;
        vecs.push_back(v);
    endtask

    // Expected per-cycle stage sequence for one instruction, from the stage rules.
    task automatic build_trace(input instr_t ins, output bit tmo);
        exp_q.delete();
        tmo = 1'b0;
        if (cfg_wmax != 0 && ins.if_d >= cfg_wmax) begin
            repeat (cfg_wmax) exp_q.push_back(S_IF);
            exp_q.push_back(S_HALT);
            tmo = 1'b1;
            return;
        end
        repeat (ins.if_d + 1) exp_q.push_back(S_IF);
        exp_q.push_back(S_RR);
        exp_q.push_back(S_EX);
        if (ins.hlt) begin
            exp_q.push_back(S_HALT);
            return;
        end
        if (ins.ld || ins.st) begin
            if (cfg_wmax != 0 && ins.ma_d >= cfg_wmax) begin
                repeat (cfg_wmax) exp_q.push_back(S_MA);
                exp_q.push_back(S_HALT);
                tmo = 1'b1;
                return;
            end
            repeat (ins.ma_d + 1) exp_q.push_back(S_MA);
        end else if (!cfg_skip) begin
            exp_q.push_back(S_MA);
        end
        exp_q.push_back(S_RW);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input bit sb);
        sel_b = sb;
        rst_a = 1'b1; rst_b = 1'b1;
        imem_ack = 0; dmem_ack = 0; is_load = 0; is_store = 0; is_halt = 0; reg_we_dec = 0; npc = 0;
        #1;
        chk("rst_pc", o_pc, 32'h8000);
        chk("rst_cnt", o_cnt, 0);
        chk("rst_dmem_req", o_dmem_req, 0);
        chk("rst_reg_we", o_reg_we, 0);
        @(negedge clk);
        #1;
        chk("rst_stage", o_stage, S_IF);
        chk("rst_halted", o_halted, 0);
        chk("rst_tmo", o_tmo, 0);
        chk("rst_clears", {o_dec_clear, o_alu_clear, o_dmem_we}, 0);
        if (sb) rst_b = 1'b0; else rst_a = 1'b0;
        cfg_skip = !sb;
        cfg_wmax = sb ? 255 : 4;
        cfg_mask = sb ? 32'hFFFF_FFFF : 32'hF;
        mdl_pc = 32'h8000; mdl_cnt = 0; mdl_halt = 0; mdl_tmo = 0;
        prev_stage = 3'd7; runlen = 0;
    endtask

    task automatic run_instr(input instr_t ins, input bit noise);
        bit tmo;
        logic [2:0] cur, es;
        build_trace(ins, tmo);
        for (int k = 0; k < exp_q.size(); k++) begin
            es  = exp_q[k];
            cur = o_stage;
            if (cur == prev_stage) runlen++; else runlen = 0;
            prev_stage = cur;
            npc = ins.npc;
            if (noise && (cur == S_IF || cur == S_RR)) begin
                is_load = 1'($urandom); is_store = 1'($urandom);
                is_halt = 1'($urandom); reg_we_dec = 1'($urandom);
            end else begin
                is_load = ins.ld; is_store = ins.st; is_halt = ins.hlt; reg_we_dec = ins.we;
            end
            if (cur == S_IF) imem_ack = (runlen == ins.if_d);
            else             imem_ack = noise ? 1'($urandom) : 1'b0;
            if (cur == S_MA && (ins.ld || ins.st)) dmem_ack = (runlen == ins.ma_d);
            else                                   dmem_ack = noise ? 1'($urandom) : 1'b0;
            #1;
            chk("stage", o_stage, es);
            chk("imem_req", o_imem_req, es == S_IF);
            chk("dmem_req", o_dmem_req, es == S_MA && (ins.ld || ins.st));
            chk("dmem_we", o_dmem_we, es == S_MA && ins.st);
            chk("reg_we", o_reg_we, es == S_RW && ins.we);
            chk("dec_clear", o_dec_clear, es == S_RR);
            chk("alu_clear", o_alu_clear, es == S_EX);
            chk("halted", o_halted, es == S_HALT);
            chk("timeout_err", o_tmo, mdl_tmo | (es == S_HALT && tmo));
            chk("pc", o_pc, mdl_pc);
            chk("retire_cnt", o_cnt, mdl_cnt);
            @(negedge clk);
        end
        if (exp_q[exp_q.size()-1] == S_RW) begin
            mdl_pc  = ins.npc;
            mdl_cnt = (mdl_cnt + 1) & cfg_mask;
        end else begin
            mdl_halt = 1'b1;
            mdl_tmo  = mdl_tmo | tmo;
        end
    endtask

    task automatic hold_halt(input int n);
        for (int k = 0; k < n; k++) begin
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            is_store = 1'b1; is_load = 1'($urandom); reg_we_dec = 1'b1;
            #1;
            chk("halt_stage", o_stage, S_HALT);
            chk("halt_halted", o_halted, 1);
            chk("halt_reqs", {o_imem_req, o_dmem_req, o_dmem_we, o_reg_we}, 0);
            chk("halt_pc", o_pc, mdl_pc);
            chk("halt_cnt", o_cnt, mdl_cnt);
            chk("halt_tmo", o_tmo, mdl_tmo);
            @(negedge clk);
        end
    endtask

    function automatic instr_t rand_instr(int maxd, bit allow_halt);
        instr_t r;
        r.ld   = ($urandom_range(0, 2) == 0);
        r.st   = !r.ld && ($urandom_range(0, 2) == 0);
        r.hlt  = allow_halt && ($urandom_range(0, 9) == 0);
        r.we   = 1'($urandom);
        r.if_d = $urandom_range(0, maxd);
        r.ma_d = $urandom_range(0, maxd);
        r.npc  = $urandom & 32'hFFFC;
        return r;
    endfunction

    // ---------------- test ----------------
    initial begin
        rst_a = 1; rst_b = 1;
        imem_ack = 0; dmem_ack = 0; is_load = 0; is_store = 0; is_halt = 0; reg_we_dec = 0; npc = 0;

        // sel_b, instruction{ld,st,hlt,we,if_d,ma_d,npc}, end stage, pc, retire_cnt, timeout
        add_vec(0, mk(0, 0, 0, 1, 0, 0, 32'h8004), S_IF,   32'h8004, 1, 0);
        add_vec(0, mk(0, 1, 0, 0, 0, 3, 32'h8008), S_IF,   32'h8008, 1, 0);
        add_vec(0, mk(1, 0, 0, 1, 2, 0, 32'h8100), S_IF,   32'h8100, 1, 0);
        add_vec(0, mk(0, 0, 0, 1, 4, 0, 32'h8004), S_HALT, 32'h8000, 0, 1);
        add_vec(0, mk(0, 0, 0, 1, 3, 0, 32'h8020), S_IF,   32'h8020, 1, 0);
        add_vec(0, mk(1, 0, 0, 1, 0, 4, 32'h8004), S_HALT, 32'h8000, 0, 1);
        add_vec(0, mk(1, 0, 0, 1, 0, 3, 32'h8030), S_IF,   32'h8030, 1, 0);
        add_vec(0, mk(1, 0, 1, 1, 0, 0, 32'h8004), S_HALT, 32'h8000, 0, 0);
        add_vec(1, mk(0, 0, 0, 1, 0, 0, 32'h8040), S_IF,   32'h8040, 1, 0);
        add_vec(1, mk(0, 1, 0, 0, 1, 2, 32'h8044), S_IF,   32'h8044, 1, 0);
        add_vec(1, mk(0, 0, 0, 0, 6, 0, 32'h8048), S_IF,   32'h8048, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset(vecs[i].sel_b);
            run_instr(vecs[i].ins, 1'b0);
            chk($sformatf("vec%0d_stage", i), o_stage, vecs[i].exp_stage);
            chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_cnt", i), o_cnt, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_tmo", i), o_tmo, vecs[i].exp_tmo);
        end

        // Halt with a store decoded alongside: no memory access, no retire, held.
        do_reset(0);
        run_instr(mk(0, 0, 0, 1, 0, 0, 32'h8010), 1'b0);
        run_instr(mk(0, 1, 1, 1, 0, 0, 32'h9000), 1'b0);
        hold_halt(100);
        chk("halt_hold_pc", o_pc, 32'h8010);
        chk("halt_hold_cnt", o_cnt, 1);

        // Sixteen retirements wrap a 4-bit counter back to zero.
        do_reset(0);
        for (int i = 0; i < 16; i++) run_instr(rand_instr(3, 1'b0), 1'b1);
        chk("wrap_cnt", o_cnt, 0);

        // Reset while a store is waiting in MA.
        do_reset(0);
        run_instr(mk(0, 0, 0, 1, 0, 0, 32'h8004), 1'b0);
        is_store = 1; is_load = 0; reg_we_dec = 1; imem_ack = 1; dmem_ack = 0;
        @(negedge clk);
        imem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_ma_stage", o_stage, S_MA);
        chk("mid_ma_req", {o_dmem_req, o_dmem_we}, 2'b11);
        @(negedge clk);
        rst_a = 1;
        @(negedge clk);
        #1;
        chk("ma_rst_stage", o_stage, S_IF);
        chk("ma_rst_pc", o_pc, 32'h8000);
        chk("ma_rst_cnt", o_cnt, 0);
        chk("ma_rst_dmem", {o_dmem_req, o_reg_we}, 0);
        rst_a = 0;
        #1;
        chk("post_rst_imem_req", o_imem_req, 1);
        is_store = 0; reg_we_dec = 0;
        mdl_pc = 32'h8000; mdl_cnt = 0; mdl_halt = 0; mdl_tmo = 0; prev_stage = 3'd7; runlen = 0;
        run_instr(mk(0, 0, 0, 1, 1, 0, 32'h8050), 1'b0);
        chk("post_rst_retire", o_cnt, 1);

        // Random instruction streams on both configurations.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(pass[0]);
            for (int i = 0; i < 40; i++) begin
                if (mdl_halt) begin
                    hold_halt(3);
                    do_reset(pass[0]);
                end
                run_instr(rand_instr(pass == 0 ? 4 : 6, 1'b1), 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
